seg_scan_driver_n: RTL and testbench
====================================

Name: seg_scan_driver_n

Overview:
Parametrised multiplexed seven-segment scan driver, the successor to the fixed 8-digit driver. It scans p_digits common-anode/cathode digits from a packed nibble bus. It adds per-digit decimal points, a hex/decimal decode mode, leading-zero blanking, 16-level PWM brightness, a ghost-guard blank interval, and frame-synchronous shadow loading so the display never tears. It sits between the measurement/formatting logic and the board's segment and digit-select pins.

Parameters:
p_system_clk, 100_000_000, clk frequency in Hz
p_digits, 8, number of digits (2..16)
p_slot_hz, 1000, per-digit slot rate; slot length L = p_system_clk / p_slot_hz cycles
p_blank_cycles, 4, dark cycles at the end of every slot (ghost guard); elaboration error if L - p_blank_cycles < 16
p_seg_active_high, 1, 1 = segment pins active high, 0 = inverted
p_pos_active_high, 1, 1 = digit-select pins active high, 0 = inverted

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
i_data  in  4*p_digits  packed nibbles; digit k = i_data[4k+3:4k], digit 0 = least significant / rightmost
i_dp  in  p_digits  decimal point per digit, bit k -> digit k
i_hex_mode  in  1  1 = nibbles 10..15 shown as A..F; 0 = shown blank
i_lz_blank  in  1  1 = suppress leading zeros
i_brightness  in  4  PWM level, 0 = dimmest, 15 = full
i_update  in  1  one-cycle strobe that captures i_data, i_dp, i_hex_mode, i_lz_blank
o_seg_pos  out  p_digits  digit select, one-hot when lit
o_seg  out  8  segments a..g = bits 0..6, dp = bit 7
o_frame_done  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Counters:
  - Slot counter cnt runs 0..L-1 and wraps.
  - Digit index idx advances when cnt == L-1 and wraps from p_digits-1 to 0.
  - Frame boundary FB = (cnt == L-1 && idx == p_digits-1).
- Shadow loading:
  - i_update writes the i_* values into a pending register set.
  - At FB, the active set takes pending.
  - If i_update and FB occur in the same cycle, both active and pending take the i_* values directly.
  - i_update mid-frame must not change the digits shown until the next FB.
  - i_brightness is not shadowed; it is sampled live.
- Brightness window:
  - S = (L - p_blank_cycles) / 16 (integer division).
  - lit = (cnt < S*(i_brightness+1)).
  - cnt >= L - p_blank_cycles is always dark.
- Decode (logical, active high):
  - 0..9 -> 3f 06 5b 4f 66 6d 7d 07 7f 6f.
  - Hex mode 10..15 -> 77 7c 39 5e 79 71.
  - Decimal mode 10..15 -> 00.
  - Bit 7 = active dp[idx].
- Leading-zero blanking: with lz_blank = 1, digit k (k >= 1) is blanked (a..g = 0) when its nibble and every higher nibble are 0. Digit 0 is never blanked. A blanked digit still shows its dp.
- Output drive:
  - When lit: o_seg_pos = one-hot(idx), o_seg = decode.
  - When dark: o_seg_pos = 0 and o_seg = 0 (logical).
  - Each output is XOR-inverted per its polarity parameter.
- Latency: o_seg, o_seg_pos and o_frame_done are registered. Outputs at cycle t+1 reflect cnt/idx/active at cycle t. o_frame_done is high in the cycle after FB.
- Reset (asynchronous, any time including mid-slot):
  - cnt = 0, idx = 0.
  - Pending and active sets = 0 (data, dp, modes).
  - o_frame_done = 0.
  - o_seg = logical 00 (8'hFF if p_seg_active_high = 0).
  - o_seg_pos = logical all-off (all ones if p_pos_active_high = 0).
  - After release, scanning resumes from digit 0, cnt 0.

Test Plan:
Bench parameters for all scenarios: p_system_clk = 3600, p_slot_hz = 100 (L = 36), p_digits = 4, p_blank_cycles = 4 (S = 2).
1. Basic scan:
   - Stimulus: i_data = 16'h1234, hex = 0, lz = 0, brightness = 15, i_update, wait one FB.
   - Required: digit 0 shows o_seg = 66 with o_seg_pos = 0001 for 32 cycles, then 4 dark cycles.
   - Then 4f/0010, 5b/0100, 06/1000 follow in order.
   - o_frame_done pulses every 144 cycles.
2. Brightness:
   - Stimulus: brightness = 0, then 7.
   - Required: each slot has exactly 2 lit cycles for brightness = 0, and 16 lit cycles for brightness = 7.
   - All remaining cycles of the slot have o_seg_pos = 0000.
3. Hex/decimal mode:
   - Stimulus: i_data = 16'hABCD with hex = 1.
   - Required: digits 0..3 show 5e, 39, 7c, 77.
   - Same data with hex = 0: all four digits show 00 while o_seg_pos still scans.
4. Leading zeros and dp:
   - Stimulus: i_data = 16'h0050, lz = 1, i_dp = 4'b1000.
   - Required: digit 3 = 80, digit 2 = 00, digit 1 = 6d, digit 0 = 3f.
   - With i_data = 0: only digit 0 shows 3f.
5. Tear-free update:
   - Stimulus: 16'h1234 active; i_update with 16'h9999 at cnt = 10 of digit 1.
   - Required: digits 1..3 keep showing 4f, 5b, 06 for the rest of the frame; all digits show 6f from the next frame onward.
   - Stimulus: i_update coincident with FB.
   - Required: the new value is displayed from the very next slot.
6. Polarity and reset:
   - Stimulus: p_seg_active_high = 0, p_pos_active_high = 0; assert rstn low mid-slot.
   - Required: o_seg = FF and o_seg_pos = 1111 immediately, with no clk edge needed.
   - On release, digit 0 is selected first as o_seg_pos = 1110.

Source files
------------

// File: rtl/seg_scan_driver_n.sv
// Multiplexed seven-segment scan driver: per-slot digit scanning with PWM brightness,
// ghost-guard blanking, leading-zero suppression and frame-synchronous shadow loading.
module seg_scan_driver_n #(
  parameter int p_system_clk      = 100_000_000,
  parameter int p_digits          = 8,
  parameter int p_slot_hz         = 1000,
  parameter int p_blank_cycles    = 4,
  parameter int p_seg_active_high = 1,
  parameter int p_pos_active_high = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [4*p_digits-1:0]   i_data,
  input  logic [p_digits-1:0]     i_dp,
  input  logic                    i_hex_mode,
  input  logic                    i_lz_blank,
  input  logic [3:0]              i_brightness,
  input  logic                    i_update,
  output logic [p_digits-1:0]     o_seg_pos,
  output logic [7:0]              o_seg,
  output logic                    o_frame_done
);

  localparam int L       = p_system_clk / p_slot_hz;
  localparam int LIT_LEN = L - p_blank_cycles;
  localparam int S       = LIT_LEN / 16;
  localparam int CW      = $clog2(L);
  localparam int IW      = $clog2(p_digits);
  localparam logic [7:0]          SEG_INV = (p_seg_active_high != 0) ? 8'h00 : 8'hFF;
  localparam logic [p_digits-1:0] POS_INV = (p_pos_active_high != 0) ? '0 : '1;

  generate
    if (LIT_LEN < 16) begin : g_bad_slot
      $error("seg_scan_driver_n: slot too short for 16 brightness steps");
    end
    if (p_digits < 2 || p_digits > 16) begin : g_bad_digits
      $error("seg_scan_driver_n: p_digits must be 2..16");
    end
  endgenerate

  logic [CW-1:0]           cnt_r;
  logic [IW-1:0]           idx_r;
  logic [4*p_digits-1:0]   pend_data_r, act_data_r;
  logic [p_digits-1:0]     pend_dp_r, act_dp_r;
  logic                    pend_hex_r, act_hex_r, pend_lz_r, act_lz_r;
  logic [7:0]              seg_r;
  logic [p_digits-1:0]     pos_r;
  logic                    frame_done_r;

  logic                    fb_s, lit_s, blank_s, dp_s;
  logic [3:0]              nib_s;
  logic [p_digits:0]       hz_s;
  logic [31:0]             lim_s;
  logic [7:0]              seg_s;
  logic [p_digits-1:0]     pos_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic hex);
    logic [6:0] r;
    case (nib)
      4'h0: r = 7'h3f;
      4'h1: r = 7'h06;
      4'h2: r = 7'h5b;
      4'h3: r = 7'h4f;
      4'h4: r = 7'h66;
      4'h5: r = 7'h6d;
      4'h6: r = 7'h7d;
      4'h7: r = 7'h07;
      4'h8: r = 7'h7f;
      4'h9: r = 7'h6f;
      4'hA: r = hex ? 7'h77 : 7'h00;
      4'hB: r = hex ? 7'h7c : 7'h00;
      4'hC: r = hex ? 7'h39 : 7'h00;
      4'hD: r = hex ? 7'h5e : 7'h00;
      4'hE: r = hex ? 7'h79 : 7'h00;
      4'hF: r = hex ? 7'h71 : 7'h00;
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  assign fb_s = (cnt_r == CW'(L - 1)) && (idx_r == IW'(p_digits - 1));

  // Slot counter and digit index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (cnt_r == CW'(L - 1)) begin
      cnt_r <= '0;
      if (idx_r == IW'(p_digits - 1)) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IW'(1);
      end
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Shadow registers: pending captures updates, active only changes at the frame boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_data_r <= '0;
      pend_dp_r   <= '0;
      pend_hex_r  <= 1'b0;
      pend_lz_r   <= 1'b0;
      act_data_r  <= '0;
      act_dp_r    <= '0;
      act_hex_r   <= 1'b0;
      act_lz_r    <= 1'b0;
    end else begin
      if (i_update) begin
        pend_data_r <= i_data;
        pend_dp_r   <= i_dp;
        pend_hex_r  <= i_hex_mode;
        pend_lz_r   <= i_lz_blank;
      end
      if (fb_s && i_update) begin
        act_data_r <= i_data;
        act_dp_r   <= i_dp;
        act_hex_r  <= i_hex_mode;
        act_lz_r   <= i_lz_blank;
      end else if (fb_s) begin
        act_data_r <= pend_data_r;
        act_dp_r   <= pend_dp_r;
        act_hex_r  <= pend_hex_r;
        act_lz_r   <= pend_lz_r;
      end
    end
  end

  // Current digit selection, leading-zero detection and lit window
  always_comb begin
    nib_s   = 4'h0;
    dp_s    = 1'b0;
    blank_s = 1'b0;
    hz_s    = '0;
    hz_s[p_digits] = 1'b1;
    for (int k = p_digits - 1; k >= 0; k--) begin
      hz_s[k] = hz_s[k+1] & (act_data_r[4*k +: 4] == 4'h0);
    end
    for (int k = 0; k < p_digits; k++) begin
      nib_s  = (idx_r == IW'(k)) ? act_data_r[4*k +: 4] : nib_s;
      dp_s   = (idx_r == IW'(k)) ? act_dp_r[k] : dp_s;
      pos_s[k] = (idx_r == IW'(k));
    end
    for (int k = 1; k < p_digits; k++) begin
      blank_s = (idx_r == IW'(k)) ? (act_lz_r & hz_s[k]) : blank_s;
    end
    lim_s = 32'(S) * (32'(i_brightness) + 32'd1);
    if ((32'(cnt_r) < lim_s) && (32'(cnt_r) < 32'(LIT_LEN))) begin
      lit_s = 1'b1;
    end else begin
      lit_s = 1'b0;
    end
    if (lit_s) begin
      seg_s = {dp_s, blank_s ? 7'h00 : seg_decode(nib_s, act_hex_r)};
    end else begin
      seg_s = 8'h00;
      pos_s = '0;
    end
  end

  // Registered, polarity-adjusted pin drive
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_r        <= SEG_INV;
      pos_r        <= POS_INV;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_s ^ SEG_INV;
      pos_r        <= pos_s ^ POS_INV;
      frame_done_r <= fb_s;
    end
  end

  assign o_seg        = seg_r;
  assign o_seg_pos    = pos_r;
  assign o_frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_driver_n.sv
// Bench for seg_scan_driver_n: two instances (active-high and inverted pins) checked every
// cycle against a slot/frame arithmetic model, plus directed checks of the documented scenarios.
module tb_seg_scan_driver_n;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] i_data;
  logic [3:0]  i_dp;
  logic        i_hex_mode, i_lz_blank, i_update;
  logic [3:0]  i_brightness;
  logic [3:0]  pos_h, pos_l;
  logic [7:0]  seg_h, seg_l;
  logic        fd_h, fd_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_driver_n #(.p_system_clk(3600), .p_digits(4), .p_slot_hz(100), .p_blank_cycles(4),
                      .p_seg_active_high(1), .p_pos_active_high(1)) dut_h (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_dp(i_dp), .i_hex_mode(i_hex_mode),
    .i_lz_blank(i_lz_blank), .i_brightness(i_brightness), .i_update(i_update),
    .o_seg_pos(pos_h), .o_seg(seg_h), .o_frame_done(fd_h));

  seg_scan_driver_n #(.p_system_clk(3600), .p_digits(4), .p_slot_hz(100), .p_blank_cycles(4),
                      .p_seg_active_high(0), .p_pos_active_high(0)) dut_l (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_dp(i_dp), .i_hex_mode(i_hex_mode),
    .i_lz_blank(i_lz_blank), .i_brightness(i_brightness), .i_update(i_update),
    .o_seg_pos(pos_l), .o_seg(seg_l), .o_frame_done(fd_l));

  // Reference model state: cycle number since reset release plus pending/active sets
  logic [7:0]  tab [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                            8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71};
  int          m_n;
  logic [15:0] m_act_data, m_pend_data;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_act_hex, m_pend_hex, m_act_lz, m_pend_lz;
  bit          last_fb;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (model cycle %0d)", tag, got, exp, m_n);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_act_data = '0; m_pend_data = '0;
    m_act_dp = '0;   m_pend_dp = '0;
    m_act_hex = 1'b0; m_pend_hex = 1'b0;
    m_act_lz = 1'b0;  m_pend_lz = 1'b0;
  endtask

  function automatic logic [7:0] m_seg(input int d);
    int nib, a;
    nib = (m_act_data >> (4 * d)) & 15;
    a = (nib < 10 || m_act_hex) ? int'(tab[nib]) : 0;
    if (m_act_lz && d >= 1 && (m_act_data >> (4 * d)) == 0) a = 0;
    return {m_act_dp[d], 7'(a)};
  endfunction

  task automatic tick();
    int c, d;
    bit lit, fb;
    logic [7:0] es;
    logic [3:0] ep, epn;
    c = m_n % 36;
    d = (m_n / 36) % 4;
    lit = (c < 2 * (int'(i_brightness) + 1)) && (c < 32);
    es = lit ? m_seg(d) : 8'h00;
    ep = lit ? (4'b0001 << d) : 4'b0000;
    epn = ~ep;
    fb = (c == 35) && (d == 3);
    if (i_update) begin
      m_pend_data = i_data; m_pend_dp = i_dp; m_pend_hex = i_hex_mode; m_pend_lz = i_lz_blank;
    end
    if (fb) begin
      m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_hex = m_pend_hex; m_act_lz = m_pend_lz;
    end
    m_n++;
    @(posedge clk);
    #1;
    chk("seg", seg_h, es);
    chk("seg_inv", seg_l, ~es);
    chk("pos", 8'(pos_h), 8'(ep));
    chk("pos_inv", 8'(pos_l), 8'(epn));
    chk("frame_done", 8'(fd_h), 8'(fb));
    chk("frame_done_inv", 8'(fd_l), 8'(fb));
    last_fb = fb;
  endtask

  task automatic apply_update(input logic [15:0] data, input logic [3:0] dp,
                              input logic hex, input logic lz);
    i_data = data; i_dp = dp; i_hex_mode = hex; i_lz_blank = lz; i_update = 1'b1;
    tick();
    i_update = 1'b0;
  endtask

  task automatic sync_frame();
    for (int i = 0; i < 150; i++) begin
      tick();
      if (last_fb) break;
    end
  endtask

  task automatic goto_slot(input int c, input int d);
    for (int i = 0; i < 200; i++) begin
      if ((m_n % 36) == c && ((m_n / 36) % 4) == d) break;
      tick();
    end
  endtask

  // Expects to start at digit 0, cnt 0; walks one whole frame
  task automatic check_frame(input string tag, input logic [31:0] exp);
    for (int d = 0; d < 4; d++) begin
      tick();
      chk(tag, seg_h, exp[8*d +: 8]);
      chk({tag, "_pos"}, 8'(pos_h), 8'(4'b0001 << d));
      repeat (35) tick();
    end
  endtask

  initial begin
    int lit_cnt;
    logic [15:0] rd;
    rstn = 1'b0;
    i_data = '0; i_dp = '0; i_hex_mode = 1'b0; i_lz_blank = 1'b0; i_update = 1'b0;
    i_brightness = 4'd15;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", seg_h, 8'h00);
    chk("rst_pos", 8'(pos_h), 8'h00);
    chk("rst_fd", 8'(fd_h), 8'h00);
    chk("rst_seg_inv", seg_l, 8'hFF);
    chk("rst_pos_inv", 8'(pos_l), 8'h0F);
    rstn = 1'b1;

    // Basic scan of 1234
    apply_update(16'h1234, 4'b0000, 1'b0, 1'b0);
    sync_frame();
    check_frame("basic", 32'h065b4f66);

    // Brightness windows
    for (int b = 0; b < 2; b++) begin
      i_brightness = (b == 0) ? 4'd0 : 4'd7;
      sync_frame();
      for (int d = 0; d < 4; d++) begin
        lit_cnt = 0;
        repeat (36) begin
          tick();
          if (pos_h != 4'b0000) lit_cnt++;
        end
        chk((b == 0) ? "lit_b0" : "lit_b7", 8'(lit_cnt), (b == 0) ? 8'd2 : 8'd16);
      end
    end
    i_brightness = 4'd15;

    // Hex vs decimal mode
    apply_update(16'hABCD, 4'b0000, 1'b1, 1'b0);
    sync_frame();
    check_frame("hex", 32'h777c395e);
    apply_update(16'hABCD, 4'b0000, 1'b0, 1'b0);
    sync_frame();
    check_frame("dec", 32'h00000000);

    // Leading zeros and decimal point
    apply_update(16'h0050, 4'b1000, 1'b0, 1'b1);
    sync_frame();
    check_frame("lz", 32'h80006d3f);
    apply_update(16'h0000, 4'b0000, 1'b0, 1'b1);
    sync_frame();
    check_frame("lz_zero", 32'h0000003f);

    // Tear-free update mid-frame
    apply_update(16'h1234, 4'b0000, 1'b0, 1'b0);
    sync_frame();
    goto_slot(10, 1);
    apply_update(16'h9999, 4'b0000, 1'b0, 1'b0);
    tick();
    chk("tear_d1", seg_h, 8'h4f);
    goto_slot(0, 2);
    tick();
    chk("tear_d2", seg_h, 8'h5b);
    goto_slot(0, 3);
    tick();
    chk("tear_d3", seg_h, 8'h06);
    sync_frame();
    check_frame("after_tear", 32'h6f6f6f6f);

    // Update coincident with the frame boundary
    goto_slot(35, 3);
    apply_update(16'h8888, 4'b0000, 1'b0, 1'b0);
    tick();
    chk("fb_update", seg_h, 8'h7f);
    chk("fb_update_pos", 8'(pos_h), 8'h01);

    // Asynchronous reset mid-slot
    goto_slot(12, 2);
    tick();
    rstn = 1'b0;
    #2;
    chk("arst_seg_inv", seg_l, 8'hFF);
    chk("arst_pos_inv", 8'(pos_l), 8'h0F);
    chk("arst_seg", seg_h, 8'h00);
    chk("arst_pos", 8'(pos_h), 8'h00);
    chk("arst_fd", 8'(fd_h), 8'h00);
    @(posedge clk);
    #1;
    chk("arst_hold_pos_inv", 8'(pos_l), 8'h0F);
    rstn = 1'b1;
    model_reset();
    tick();
    chk("post_rst_pos_inv", 8'(pos_l), 8'h0E);
    chk("post_rst_seg_inv", seg_l, 8'hC0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 4; k++) rd[4*k +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
      i_data = rd;
      i_dp = 4'($urandom_range(15));
      i_hex_mode = 1'($urandom_range(1));
      i_lz_blank = 1'($urandom_range(1));
      i_update = ($urandom_range(39) == 0);
      if ($urandom_range(29) == 0) i_brightness = 4'($urandom_range(15));
      tick();
      i_update = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
